comparator_stim_driver: RTL and testbench

Hardware stimulus sequencer and response checker for the single-bit comparator (z = x XNOR y, i.e. z=1 when x==y). It drives the comparator's x/y inputs from a programmable table of (delay, x, y) steps and samples z after a settle time. It counts mismatches against the expected equality result and reports pass/fail. It is the on-chip counterpart of the bench stimulus, used for self-test of comparator instances.

---
 rtl/comparator_stim_driver.sv | 172 +++++++++++++++++
 tb/tb_comparator_stim_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_stim_driver.sv
// Table-driven stimulus sequencer and XNOR response checker
// for self-test of single-bit comparator instances.
module comparator_stim_driver #(
  parameter int DELAY_W = 8,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DELAY_W+1:0] cfg_wdata,
  input  logic [ADDR_W:0]    num_steps,
  input  logic               start,
  input  logic               z,
  output logic               x,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [3:0]         err_count,
  output logic [ADDR_W-1:0]  step
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SETTLE
  } state_t;

  logic [DELAY_W+1:0] tbl_q [DEPTH];

  state_t             state_q, state_d;
  logic [ADDR_W:0]    n_q, n_d;
  logic [ADDR_W-1:0]  step_q, step_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]      scnt_q, scnt_d;
  logic               x_q, x_d;
  logic               y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [3:0]         err_q, err_d;

  logic [ADDR_W-1:0]  step_nx;
  logic               miss;
  logic [3:0]         err_s;
  logic               last;

  assign step_nx = step_q + ADDR_W'(1);
  assign miss    = z != (x_q ~^ y_q);
  assign last    = {1'b0, step_q} == (n_q - (ADDR_W+1)'(1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    scnt_d  = scnt_q;
    x_d     = x_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    err_s   = err_q;
    if (miss && err_q != 4'hf) begin
      err_s = err_q + 4'd1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_steps == '0) begin
            done_d = 1'b1;
            pass_d = 1'b1;
            err_d  = '0;
          end else begin
            n_d     = (num_steps > DEPTH_N) ? DEPTH_N : num_steps;
            step_d  = '0;
            cnt_d   = tbl_q[0][DELAY_W+1:2];
            err_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_W'(1);
        end else begin
          x_d     = tbl_q[step_q][1];
          y_d     = tbl_q[step_q][0];
          scnt_d  = SETTLE_M1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (scnt_q != '0) begin
          scnt_d = scnt_q - SW'(1);
        end else begin
          err_d = err_s;
          if (last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = err_s == '0;
            state_d = S_IDLE;
          end else begin
            step_d  = step_nx;
            cnt_d   = tbl_q[step_nx][DELAY_W+1:2];
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      scnt_q  <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      scnt_q  <= scnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  // Step-0 delay is read above before this write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we && !busy_q) begin
      tbl_q[cfg_addr] <= cfg_wdata;
    end
  end

  assign x         = x_q;
  assign y         = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign step      = step_q;

endmodule

// File: tb/tb_comparator_stim_driver.sv
// Randomized bench for comparator_stim_driver against a
// step-list timing/error model.
module tb_comparator_stim_driver;

  localparam int DW     = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int SETTLE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW+1:0] cfg_wdata = '0;
  logic [AW:0]   num_steps = '0;
  logic          start = 1'b0;
  logic          z;
  logic          x, y, busy, done, pass;
  logic [3:0]    err_count;
  logic [AW-1:0] step;

  int zmode = 0;
  int n_chk = 0;
  int n_fail = 0;

  int m_d [DEPTH];
  bit m_x [DEPTH];
  bit m_y [DEPTH];
  bit cur_x = 0;
  bit cur_y = 0;

  comparator_stim_driver #(
    .DELAY_W(DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .SETTLE (SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .num_steps(num_steps),
    .start    (start),
    .z        (z),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .step     (step)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (zmode)
      0:       z = (x == y);
      1:       z = 1'b0;
      2:       z = 1'b1;
      default: z = (x != y);
    endcase
  end

  function automatic bit zexp(int mode, bit a, bit b);
    case (mode)
      0:       return a == b;
      1:       return 1'b0;
      2:       return 1'b1;
      default: return a != b;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(int a, int d, bit xv, bit yv);
    cfg_we    = 1'b1;
    cfg_addr  = AW'(a);
    cfg_wdata = {DW'(d), xv, yv};
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_d[a] = d;
    m_x[a] = xv;
    m_y[a] = yv;
  endtask

  task automatic run(int nreq, int mode, int inj);
    int n, lat, idx, err;
    int app [DEPTH];
    zmode     = mode;
    num_steps = (AW+1)'(nreq);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cfg_we = 1'b0;
    if (nreq == 0) begin
      chk("zero_done", 32'(done), 1);
      chk("zero_pass", 32'(pass), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_err", 32'(err_count), 0);
      chk("zero_x", 32'(x), 32'(cur_x));
      chk("zero_y", 32'(y), 32'(cur_y));
      return;
    end
    n   = (nreq > DEPTH) ? DEPTH : nreq;
    lat = 0;
    err = 0;
    for (int i = 0; i < n; i++) begin
      app[i] = lat + m_d[i] + 1;
      lat += m_d[i] + 1 + SETTLE;
      if (zexp(mode, m_x[i], m_y[i]) != (m_x[i] == m_y[i]) && err < 15)
        err++;
    end
    chk("busy_on", 32'(busy), 1);
    chk("done_clr", 32'(done), 0);
    chk("err_clr", 32'(err_count), 0);
    idx = 0;
    for (int k = 1; k <= lat; k++) begin
      if (k == inj) begin
        start     = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = AW'($urandom);
        cfg_wdata = (DW+2)'($urandom);
      end else begin
        start  = 1'b0;
        cfg_we = 1'b0;
      end
      @(posedge clk);
      #1;
      if (idx < n && k == app[idx]) begin
        cur_x = m_x[idx];
        cur_y = m_y[idx];
        idx++;
      end
      chk("x", 32'(x), 32'(cur_x));
      chk("y", 32'(y), 32'(cur_y));
      if (k < lat) chk("busy", 32'(busy), 1);
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    chk("done", 32'(done), 1);
    chk("busy_off", 32'(busy), 0);
    chk("pass", 32'(pass), 32'(err == 0));
    chk("err", 32'(err_count), err);
    chk("step", 32'(step), n - 1);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_step"}, 32'(step), 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_d[i] = 0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    wr(0, 0, 0, 0);
    wr(1, 50, 1, 0);
    wr(2, 60, 1, 1);
    wr(3, 70, 1, 1);
    wr(4, 80, 0, 1);
    run(5, 0, 0);
    run(5, 1, 0);
    run(0, 0, 0);
    run(5, 0, 120);
    run(5, 0, 0);

    cfg_we    = 1'b1;
    cfg_addr  = AW'(3);
    cfg_wdata = {DW'(5), 1'b0, 1'b1};
    m_d[3] = 5;
    m_x[3] = 0;
    m_y[3] = 1;
    run(5, 0, 0);

    for (int i = 0; i < 8; i++) wr(i, 0, 1, 0);
    run(8, 2, 0);
    run(8, 0, 0);
    for (int i = 0; i < DEPTH; i++) wr(i, 0, 1, 0);
    run(16, 2, 0);
    run(31, 3, 0);

    for (int r = 0; r < 6; r++) begin
      int nr, lim;
      for (int i = 0; i < DEPTH; i++)
        wr(i, $urandom_range(0, 15), 1'($urandom), 1'($urandom));
      nr = $urandom_range(1, 20);
      lim = (nr > DEPTH ? DEPTH : nr) * 4;
      run(nr, $urandom_range(0, 3), $urandom_range(1, lim));
    end

    wr(0, 0, 1, 1);
    wr(1, 9, 0, 1);
    wr(2, 9, 1, 0);
    wr(3, 9, 1, 1);
    wr(4, 9, 0, 0);
    zmode     = 0;
    num_steps = (AW+1)'(5);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      m_d[i] = 0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    cur_x = 0;
    cur_y = 0;
    run(1, 0, 0);
    run(16, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
